// File: rtl/encounter_gen.sv
// encounter_gen
// -----------------------------------------------------------------------------
// Wild-encounter generator for overworld movement. A free-running Galois LFSR
// supplies a per-frame roll; while the player holds a movement key inside an
// encounter zone, a roll below the programmable rate raises an encounter
// request (fight_on) with a latched species index. The request is handshaked
// with the battle controller (fight_ack), the battle end is signalled by
// fight_done, and a cooldown window then locks out further encounters.
//
// Ports:
//   frameClk    in   frame clock
//   Reset       in   synchronous, active-high reset
//   zone_en     in   player is standing in an encounter zone
//   keycode     in   current USB keycode (W/S/D/A count as movement)
//   rate        in   encounter threshold, hit when roll < rate
//   seed_we     in   load seed into the LFSR this cycle
//   seed        in   seed value (0 loads the default SEED)
//   fight_ack   in   battle controller accepted the encounter
//   fight_done  in   battle finished (single-cycle pulse)
//   fight_on    out  encounter pending, held until acknowledged
//   species     out  latched species index
//   gg          out  status: 01 IDLE, 11 PENDING, 10 BATTLE, 00 COOLDOWN
//   enc_count   out  (ENCOUNTER_STATS_EN only) saturating encounter counter
//
// Optional feature macro: ENCOUNTER_STATS_EN adds the enc_count port.
// -----------------------------------------------------------------------------
module encounter_gen #(
  parameter int          LFSR_W      = 16,
  parameter int          RATE_W      = 8,
  parameter int          SPECIES_W   = 2,
  parameter int          NUM_SPECIES = 4,
  parameter int          COOLDOWN    = 120,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                 frameClk,
  input  logic                 Reset,
  input  logic                 zone_en,
  input  logic [7:0]           keycode,
  input  logic [RATE_W-1:0]    rate,
  input  logic                 seed_we,
  input  logic [LFSR_W-1:0]    seed,
  input  logic                 fight_ack,
  input  logic                 fight_done,
  output logic                 fight_on,
  output logic [SPECIES_W-1:0] species,
  output logic [1:0]           gg
`ifdef ENCOUNTER_STATS_EN
  ,
  output logic [7:0]           enc_count
`endif
);

  localparam logic [LFSR_W-1:0] SEED_T = SEED[LFSR_W-1:0];

  // Right-shifting Galois masks: x^16+x^14+x^13+x^11+1 and x^8+x^6+x^5+x^4+1.
  localparam logic [LFSR_W-1:0] TAPS = (LFSR_W == 8) ? LFSR_W'(8'hB8)
                                                     : LFSR_W'(16'hB400);

  // Counter only ever holds COOLDOWN-1 down to 0.
  localparam int                CNT_W   = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0]  CD_LOAD = CNT_W'(COOLDOWN - 1);

  // One extra bit so NUM_SPECIES == 2**SPECIES_W is representable.
  localparam logic [SPECIES_W:0] NUM_SP = (SPECIES_W + 1)'(NUM_SPECIES);

  localparam logic [1:0] GG_IDLE     = 2'b01;
  localparam logic [1:0] GG_PENDING  = 2'b11;
  localparam logic [1:0] GG_BATTLE   = 2'b10;
  localparam logic [1:0] GG_COOLDOWN = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PENDING,
    S_BATTLE,
    S_COOLDOWN
  } state_t;

  state_t               state;
  logic [LFSR_W-1:0]    lfsr;
  logic [LFSR_W-1:0]    lfsr_adv;
  logic [LFSR_W-1:0]    lfsr_next;
  logic [CNT_W-1:0]     cnt;
  logic [RATE_W-1:0]    roll;
  logic [SPECIES_W-1:0] top_bits;
  logic [SPECIES_W-1:0] pick;
  logic                 move;
  logic                 hit;

  // LFSR next value: seed load wins over advancing, and a zero seed is
  // replaced by SEED so the register can never lock up at all-zeros.
  always_comb begin
    lfsr_adv = lfsr >> 1;
    if (lfsr[0]) begin
      lfsr_adv = (lfsr >> 1) ^ TAPS;
    end
    lfsr_next = lfsr_adv;
    if (seed_we) begin
      lfsr_next = (seed == '0) ? SEED_T : seed;
    end
  end

  // Roll and species pick come from the current LFSR value; a hit needs the
  // player to be moving inside a zone. rate == 0 can never satisfy roll < rate.
  always_comb begin
    roll     = lfsr[RATE_W-1:0];
    top_bits = lfsr[LFSR_W-1 -: SPECIES_W];
    pick     = SPECIES_W'({1'b0, top_bits} % NUM_SP);
    move     = (keycode == 8'h1A) || (keycode == 8'h16) ||
               (keycode == 8'h07) || (keycode == 8'h04);
    hit      = zone_en && move && (roll < rate);
  end

  // Battle handshake FSM with registered outputs. gg is updated together with
  // the state so it always matches the state register.
  always_ff @(posedge frameClk) begin
    if (Reset) begin
      state    <= S_IDLE;
      lfsr     <= SEED_T;
      fight_on <= 1'b0;
      species  <= '0;
      gg       <= GG_IDLE;
      cnt      <= '0;
    end else begin
      lfsr <= lfsr_next;
      case (state)
        S_IDLE: begin
          if (hit) begin
            state    <= S_PENDING;
            species  <= pick;
            fight_on <= 1'b1;
            gg       <= GG_PENDING;
          end
        end
        // fight_done is deliberately ignored here, even alongside ack.
        S_PENDING: begin
          if (fight_ack) begin
            state    <= S_BATTLE;
            fight_on <= 1'b0;
            gg       <= GG_BATTLE;
          end
        end
        S_BATTLE: begin
          if (fight_done) begin
            if (COOLDOWN == 0) begin
              state <= S_IDLE;
              gg    <= GG_IDLE;
            end else begin
              state <= S_COOLDOWN;
              cnt   <= CD_LOAD;
              gg    <= GG_COOLDOWN;
            end
          end
        end
        // Counter runs COOLDOWN-1..0, giving exactly COOLDOWN locked cycles.
        S_COOLDOWN: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            gg    <= GG_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          fight_on <= 1'b0;
          gg       <= GG_IDLE;
        end
      endcase
    end
  end

`ifdef ENCOUNTER_STATS_EN
  // Counts IDLE->PENDING transitions, saturating at 255.
  always_ff @(posedge frameClk) begin
    if (Reset) begin
      enc_count <= 8'd0;
    end else if ((state == S_IDLE) && hit && (enc_count != 8'hFF)) begin
      enc_count <= enc_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_encounter_gen.sv
// tb_encounter_gen
// -----------------------------------------------------------------------------
// Bench for encounter_gen with default parameters. Each stimulus cycle pushes
// the expected post-edge outputs into a queue; a monitor on the falling edge
// pops and compares them. Directed hand-computed checks are layered on top.
// -----------------------------------------------------------------------------
module tb_encounter_gen;

  logic        frameClk = 1'b0;
  logic        Reset;
  logic        zone_en;
  logic [7:0]  keycode;
  logic [7:0]  rate;
  logic        seed_we;
  logic [15:0] seed;
  logic        fight_ack;
  logic        fight_done;
  logic        fight_on;
  logic [1:0]  species;
  logic [1:0]  gg;
`ifdef ENCOUNTER_STATS_EN
  logic [7:0]  enc_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  encounter_gen dut (
    .frameClk  (frameClk),
    .Reset     (Reset),
    .zone_en   (zone_en),
    .keycode   (keycode),
    .rate      (rate),
    .seed_we   (seed_we),
    .seed      (seed),
    .fight_ack (fight_ack),
    .fight_done(fight_done),
    .fight_on  (fight_on),
    .species   (species),
`ifdef ENCOUNTER_STATS_EN
    .enc_count (enc_count),
`endif
    .gg        (gg)
  );

  initial forever #5 frameClk = ~frameClk;

  always @(posedge frameClk) edge_cnt <= edge_cnt + 1;

  // Reference model state (default parameters).
  localparam logic [15:0] M_SEED = 16'hACE1;
  int          m_st;   // 0 idle, 1 pending, 2 battle, 3 cooldown
  logic [15:0] m_lfsr;
  logic        m_fo;
  logic [1:0]  m_sp;
  logic [1:0]  m_gg;
  int          m_cnt;
  int          m_enc;

  typedef struct {
    int          edge_no;
    logic        fo;
    logic [1:0]  sp;
    logic [1:0]  gg;
    logic [15:0] lfsr;
    logic [7:0]  enc;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [15:0] galois(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_step(input logic rst, input logic zone, input logic [7:0] key,
                            input logic [7:0] rt, input logic swe, input logic [15:0] sd,
                            input logic ack, input logic done);
    logic [7:0] roll;
    logic [1:0] pick;
    logic       mv;
    if (rst) begin
      m_st = 0; m_lfsr = M_SEED; m_fo = 1'b0; m_sp = 2'd0; m_gg = 2'b01;
      m_cnt = 0; m_enc = 0;
      return;
    end
    roll = m_lfsr[7:0];
    pick = 2'(m_lfsr[15:14] % 4);
    mv   = (key == 8'h1A) || (key == 8'h16) || (key == 8'h07) || (key == 8'h04);
    case (m_st)
      0: if (zone && mv && (roll < rt)) begin
           m_st = 1; m_fo = 1'b1; m_sp = pick; m_gg = 2'b11;
           if (m_enc < 255) m_enc = m_enc + 1;
         end
      1: if (ack) begin m_st = 2; m_fo = 1'b0; m_gg = 2'b10; end
      2: if (done) begin m_st = 3; m_cnt = 119; m_gg = 2'b00; end
      default: if (m_cnt == 0) begin m_st = 0; m_gg = 2'b01; end
               else m_cnt = m_cnt - 1;
    endcase
    m_lfsr = swe ? ((sd == 16'h0) ? M_SEED : sd) : galois(m_lfsr);
  endtask

  // Drive one cycle of inputs, record the expected outcome, advance past the edge.
  task automatic apply_stimulus(input logic rst, input logic zone, input logic [7:0] key,
                                input logic [7:0] rt, input logic swe, input logic [15:0] sd,
                                input logic ack, input logic done);
    exp_t e;
    Reset = rst; zone_en = zone; keycode = key; rate = rt;
    seed_we = swe; seed = sd; fight_ack = ack; fight_done = done;
    model_step(rst, zone, key, rt, swe, sd, ack, done);
    e.edge_no = edge_cnt + 1;
    e.fo = m_fo; e.sp = m_sp; e.gg = m_gg; e.lfsr = m_lfsr; e.enc = 8'(m_enc);
    exp_q.push_back(e);
    @(posedge frameClk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Scoreboard monitor: compares the DUT against each queued expectation.
  always @(negedge frameClk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
      e = exp_q.pop_front();
      check_output($sformatf("sb_fight_on@%0d", e.edge_no), 16'(fight_on), 16'(e.fo));
      check_output($sformatf("sb_gg@%0d", e.edge_no), 16'(gg), 16'(e.gg));
      check_output($sformatf("sb_lfsr@%0d", e.edge_no), dut.lfsr, e.lfsr);
      if (e.fo || e.gg == 2'b10)
        check_output($sformatf("sb_species@%0d", e.edge_no), 16'(species), 16'(e.sp));
`ifdef ENCOUNTER_STATS_EN
      check_output($sformatf("sb_enc@%0d", e.edge_no), 16'(enc_count), 16'(e.enc));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    // 1: reset, then rate 0 never hits
    apply_stimulus(1, 0, 8'h00, 8'h00, 0, 16'h0, 0, 0);
    apply_stimulus(1, 0, 8'h00, 8'h00, 0, 16'h0, 0, 0);
    check_output("reset_gg", 16'(gg), 16'h1);
    check_output("reset_fight_on", 16'(fight_on), 16'h0);
    check_output("reset_species", 16'(species), 16'h0);
    check_output("reset_lfsr", dut.lfsr, 16'hACE1);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      apply_stimulus(0, 1, 8'h1A, 8'h00, 0, 16'h0, 0, 0);
      if (fight_on !== 1'b0 || gg !== 2'b01) n++;
    end
    check_output("rate0_never_hits", 16'(n), 16'h0);

    // 2: seed C0FF -> roll FF misses at rate FF, next roll 7F hits, pick 3
    apply_stimulus(0, 0, 8'h04, 8'hFF, 1, 16'hC0FF, 0, 0);
    check_output("seed_load", dut.lfsr, 16'hC0FF);
    apply_stimulus(0, 1, 8'h04, 8'hFF, 0, 16'h0, 0, 0);
    check_output("roll_ff_misses", 16'(fight_on), 16'h0);
    apply_stimulus(0, 1, 8'h04, 8'hFF, 0, 16'h0, 0, 0);
    check_output("hit_fight_on", 16'(fight_on), 16'h1);
    check_output("hit_species", 16'(species), 16'h3);
    check_output("hit_gg", 16'(gg), 16'h3);

    // 3: pending holds without ack, then ack moves to battle
    n = 0;
    for (int i = 0; i < 50; i++) begin
      apply_stimulus(0, 1, 8'h00, 8'hFF, 0, 16'h0, 0, 0);
      if (fight_on !== 1'b1 || species !== 2'd3) n++;
    end
    check_output("pending_hold", 16'(n), 16'h0);
    apply_stimulus(0, 1, 8'h00, 8'hFF, 0, 16'h0, 1, 0);
    check_output("ack_fight_on", 16'(fight_on), 16'h0);
    check_output("ack_gg", 16'(gg), 16'h2);

    // 4: done -> exactly 120 cooldown cycles even at rate FF
    apply_stimulus(0, 1, 8'h1A, 8'hFF, 0, 16'h0, 0, 1);
    n = 0;
    while (gg == 2'b00 && n < 200) begin
      n++;
      apply_stimulus(0, 1, 8'h1A, 8'hFF, 0, 16'h0, 0, 0);
    end
    check_output("cooldown_len", 16'(n), 16'd120);
    check_output("cooldown_exit_gg", 16'(gg), 16'h1);
    check_output("cooldown_no_hit", 16'(fight_on), 16'h0);

    // 5: zero seed loads SEED; ack+done together goes to battle only
    apply_stimulus(0, 0, 8'h00, 8'hFF, 1, 16'h0000, 0, 0);
    check_output("zero_seed", dut.lfsr, 16'hACE1);
    apply_stimulus(0, 0, 8'h00, 8'hFF, 1, 16'h0001, 0, 0);
    apply_stimulus(0, 1, 8'h16, 8'hFF, 0, 16'h0, 0, 0);
    check_output("seed1_hit", 16'(fight_on), 16'h1);
    check_output("seed1_species", 16'(species), 16'h0);
    apply_stimulus(0, 1, 8'h16, 8'hFF, 0, 16'h0, 1, 1);
    check_output("ack_done_gg", 16'(gg), 16'h2);
    apply_stimulus(0, 1, 8'h16, 8'hFF, 0, 16'h0, 0, 1);
    check_output("done_gg", 16'(gg), 16'h0);

    // 6: reset mid-cooldown and mid-pending
    for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 8'h07, 8'hFF, 0, 16'h0, 0, 0);
    apply_stimulus(1, 1, 8'h07, 8'hFF, 0, 16'h0, 0, 0);
    check_output("rst_cool_gg", 16'(gg), 16'h1);
    check_output("rst_cool_lfsr", dut.lfsr, 16'hACE1);
    apply_stimulus(0, 1, 8'h07, 8'hFF, 0, 16'h0, 0, 0);
    check_output("post_rst_hit_gg", 16'(gg), 16'h3);
    apply_stimulus(1, 1, 8'h07, 8'hFF, 0, 16'h0, 0, 0);
    check_output("rst_pend_fight_on", 16'(fight_on), 16'h0);
    check_output("rst_pend_gg", 16'(gg), 16'h1);
    check_output("rst_pend_lfsr", dut.lfsr, 16'hACE1);
    apply_stimulus(0, 0, 8'h00, 8'hFF, 0, 16'h0, 1, 1);
    check_output("stray_ack_done", 16'(gg), 16'h1);

`ifdef ENCOUNTER_STATS_EN
    apply_stimulus(1, 0, 8'h00, 8'h00, 0, 16'h0, 0, 0);
    for (int k = 0; k < 300; k++) begin
      n = 0;
      while (!m_fo && n < 50) begin
        n++;
        apply_stimulus(0, 1, 8'h04, 8'hFF, 0, 16'h0, 0, 0);
      end
      apply_stimulus(0, 1, 8'h04, 8'hFF, 0, 16'h0, 1, 0);
      apply_stimulus(0, 1, 8'h04, 8'hFF, 0, 16'h0, 0, 1);
      n = 0;
      while (m_gg != 2'b01 && n < 200) begin
        n++;
        apply_stimulus(0, 0, 8'h04, 8'hFF, 0, 16'h0, 0, 0);
      end
    end
    check_output("enc_count_sat", 16'(enc_count), 16'd255);
`endif

    @(negedge frameClk);
    #1;
    check_output("scoreboard_drained", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encounter_gen.md
Name: encounter_gen

Overview:
Parametrised wild-encounter generator for overworld movement.
- Free-running LFSR gives a per-frame encounter roll while a movement key is held inside an encounter zone.
- Roll is compared against a programmable rate, a species index is latched, and the battle FSM is handshaked.
- A cooldown window follows each battle.
- Sits between keyboard/overworld logic and the battle controller; runs on frameClk.

Parameters:
LFSR_W, 16, LFSR width; legal values 8 or 16 only.
RATE_W, 8, width of rate input and of the roll compare; must be <= LFSR_W.
SPECIES_W, 2, width of species output.
NUM_SPECIES, 4, number of valid species; must be between 1 and 2**SPECIES_W.
COOLDOWN, 120, frames of encounter lockout after a battle ends; 0 allowed.
SEED, 16'hACE1, LFSR reset/default seed, truncated to LFSR_W; must be nonzero.

Ports:
frameClk  in  1  frame clock
Reset  in  1  synchronous, active-high reset
zone_en  in  1  player is in an encounter zone (grass)
keycode  in  8  current USB keycode
rate  in  RATE_W  encounter threshold; roll hits when roll < rate
seed_we  in  1  load seed into LFSR this cycle
seed  in  LFSR_W  seed value
fight_ack  in  1  battle controller accepted encounter
fight_done  in  1  battle finished (single-cycle pulse)
fight_on  out  1  encounter pending, held until ack
species  out  SPECIES_W  latched species index, valid while fight_on or in BATTLE
gg  out  2  status code: 01 IDLE, 11 PENDING, 10 BATTLE, 00 COOLDOWN

Behaviour:
Reset:
- Applies on the frameClk edge where Reset=1; overrides every other input.
- Results: state IDLE, LFSR=SEED, fight_on=0, species=0, gg=01, cooldown counter=0.
- Reset mid-PENDING/BATTLE/COOLDOWN abandons the encounter; no ack or done is required afterwards.

LFSR:
- Galois LFSR advances every cycle in every state.
- Taps: x^16+x^14+x^13+x^11+1 for 16; x^8+x^6+x^5+x^4+1 for 8.
- seed_we=1 loads seed instead of advancing; a seed of 0 loads SEED instead (no lock-up).
- roll = lfsr[RATE_W-1:0].
- pick = lfsr[LFSR_W-1 -: SPECIES_W] mod NUM_SPECIES.

Movement:
- move = keycode in {8'h1A, 8'h16, 8'h07, 8'h04} (W, S, D, A).
- Any other keycode, including 00, is not movement.

FSM:
- IDLE: if zone_en && move && roll < rate (unsigned), go to PENDING next edge. On the same edge species<=pick and fight_on<=1. fight_on is registered, so it asserts 1 cycle after the hit frame. rate=0 never hits.
- PENDING: fight_on held at 1; keycode and zone_en are ignored. On fight_ack=1: fight_on<=0, go to BATTLE. fight_done is ignored in this state, even if it arrives together with ack.
- BATTLE: species held. On fight_done=1: if COOLDOWN=0 go to IDLE, else load counter=COOLDOWN-1 and go to COOLDOWN.
- COOLDOWN: no rolls; counter decrements each cycle; at counter=0 go to IDLE. The lockout is exactly COOLDOWN cycles.
- fight_ack outside PENDING and fight_done outside BATTLE are ignored.

Output timing:
- gg is registered and reflects the current state.

Optional Feature:
ENCOUNTER_STATS_EN
- Defined: adds output port enc_count (8 bits), reset 0. It increments on each IDLE->PENDING transition and saturates at 255; Reset clears it.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset held 2 cycles, then zone_en=1, keycode=8'h1A, rate=0 for 1000 cycles -> fight_on stays 0, gg=01 throughout.
2. seed_we pulse with seed=16'h0001, rate=8'hFF, zone_en=1, keycode=8'h04 -> fight_on rises 1 cycle after the first cycle whose reference-model roll < 255. species equals the model's pick, and gg=11 on that same cycle.
3. In PENDING, hold fight_ack=0 for 50 cycles while keycode=8'h00 -> fight_on stays 1 and species is stable. Then ack=1 for 1 cycle -> fight_on=0, gg=10 on the next cycle.
4. In BATTLE, pulse fight_done with COOLDOWN=120 -> gg=00 for exactly 120 cycles with no encounter even at rate=8'hFF, then gg=01.
5. seed_we with seed=0 -> LFSR holds SEED on the next cycle. In PENDING, drive ack and done together -> goes to BATTLE, not COOLDOWN.
6. Reset asserted mid-COOLDOWN and mid-PENDING -> next cycle fight_on=0, gg=01, LFSR=SEED. With ENCOUNTER_STATS_EN, 300 forced hits -> enc_count=255.
